// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame scheduler.
package fft_pkg;

    // Samples per FFT frame and the width of a peak bucket index.
    localparam int FRAME_LEN = 4096;
    localparam int BUCKET_W  = 11;

    // Scheduler states: waiting for a tick, streaming the frame into the FFT,
    // waiting for the last magnitude, waiting for the peak search.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_MAG,
        SEARCH
    } sched_state_t;

    // Counter width able to hold values 0..limit-1 (never less than one bit).
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle counter that wraps at LIMIT-1 and flags that cycle.
// Used both as the frame tick generator and as the per-state timeout.
module cycle_timer
    import fft_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int           W    = cnt_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_reg;

    // Count 0..LIMIT-1 and wrap; clear restarts the count from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear || (count_reg == LAST)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + ONE;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Schedules periodic FFT frames: waits for a full sample buffer and a tick,
// starts the BRAM reader, follows the FFT handshakes, launches the peak
// search and publishes the resulting peak. Tracks aborts, timeouts and
// ticks dropped while a frame is still in flight.
module fft_frame_scheduler #(
    parameter int PERIOD_CYCLES  = 1_733_333,
    parameter int FRAME_LEN      = fft_pkg::FRAME_LEN,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                         clk_104mhz,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_done,
    output logic                         frame_start,
    input  logic                         frame_tvalid,
    input  logic                         frame_tready,
    input  logic                         frame_tlast,
    input  logic                         last_missing,
    input  logic                         mag_tvalid,
    input  logic                         mag_tlast,
    output logic                         search_start,
    input  logic                         search_done,
    input  logic [fft_pkg::BUCKET_W-1:0] peak_in,
    output logic [fft_pkg::BUCKET_W-1:0] peak_out,
    output logic                         peak_valid,
    output logic                         busy,
    output logic                         err_abort,
    output logic                         err_timeout,
    output logic [7:0]                   overrun_count
);

    import fft_pkg::*;

    // Fill and beat counters share a width that can hold FRAME_LEN itself.
    localparam int                FILL_W    = cnt_width(FRAME_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FRAME_LEN);
    localparam logic [FILL_W-1:0] LAST_BEAT = FILL_W'(FRAME_LEN - 1);
    localparam logic [FILL_W-1:0] ONE_F     = FILL_W'(1);

    sched_state_t      state_reg, state_next;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] beat_reg;
    logic              tick, timeout, timer_clear;
    logic              fill_full, beat;
    logic              frame_start_next, search_start_next;
    logic              peak_load, abort_set, timeout_set;

    assign fill_full = (fill_reg == FILL_FULL);
    assign beat      = frame_tvalid && frame_tready;
    assign busy      = (state_reg != IDLE);

    // The timeout count restarts on every state change and idles at zero.
    assign timer_clear = (state_reg == IDLE) || (state_next != state_reg);

    cycle_timer #(.LIMIT(PERIOD_CYCLES)) u_tick_timer (
        .clk     (clk_104mhz),
        .rst     (reset),
        .clear   (1'b0),
        .expired (tick)
    );

    cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
        .clk     (clk_104mhz),
        .rst     (reset),
        .clear   (timer_clear),
        .expired (timeout)
    );

    // Next state and one-cycle events; completing events beat the timeout.
    always_comb begin
        state_next        = state_reg;
        frame_start_next  = 1'b0;
        search_start_next = 1'b0;
        peak_load         = 1'b0;
        abort_set         = 1'b0;
        timeout_set       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tick && enable && fill_full) begin
                    state_next       = SEND;
                    frame_start_next = 1'b1;
                end
            end
            SEND: begin
                if (last_missing || (beat && frame_tlast && (beat_reg != LAST_BEAT))) begin
                    state_next = IDLE;
                    abort_set  = 1'b1;
                end else if (beat && frame_tlast) begin
                    state_next = WAIT_MAG;
                end else if (timeout) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            WAIT_MAG: begin
                if (mag_tvalid && mag_tlast) begin
                    state_next        = SEARCH;
                    search_start_next = 1'b1;
                end else if (timeout) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            SEARCH: begin
                if (search_done) begin
                    state_next = IDLE;
                    peak_load  = 1'b1;
                end else if (timeout) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_104mhz or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Registered start/valid pulses and the published peak.
    always_ff @(posedge clk_104mhz or posedge reset) begin
        if (reset) begin
            frame_start  <= 1'b0;
            search_start <= 1'b0;
            peak_valid   <= 1'b0;
            peak_out     <= '0;
        end else begin
            frame_start  <= frame_start_next;
            search_start <= search_start_next;
            peak_valid   <= peak_load;
            if (peak_load) begin
                peak_out <= peak_in;
            end
        end
    end

    // Sticky error flags and the saturating count of ticks lost while busy.
    always_ff @(posedge clk_104mhz or posedge reset) begin
        if (reset) begin
            err_abort     <= 1'b0;
            err_timeout   <= 1'b0;
            overrun_count <= '0;
        end else begin
            err_abort   <= err_abort | abort_set;
            err_timeout <= err_timeout | timeout_set;
            if (tick && busy && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

    // Buffer fill level; saturates at a full frame and stays there.
    always_ff @(posedge clk_104mhz or posedge reset) begin
        if (reset) begin
            fill_reg <= '0;
        end else if (sample_done && !fill_full) begin
            fill_reg <= fill_reg + ONE_F;
        end
    end

    // Beats accepted by the FFT in the current frame; zero outside SEND.
    always_ff @(posedge clk_104mhz or posedge reset) begin
        if (reset) begin
            beat_reg <= '0;
        end else if (state_reg != SEND) begin
            beat_reg <= '0;
        end else if (beat && (beat_reg != FILL_FULL)) begin
            beat_reg <= beat_reg + ONE_F;
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: a cycle-level behavioural model checked
// against every output each cycle, plus directed hand-computed checks.
module tb_fft_frame_scheduler;

    localparam int P  = 100;   // tick period
    localparam int FL = 256;   // frame length
    localparam int TO = 1000;  // busy-state timeout

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_done = 1'b0;
    logic        frame_tvalid = 1'b0;
    logic        frame_tready = 1'b0;
    logic        frame_tlast = 1'b0;
    logic        last_missing = 1'b0;
    logic        mag_tvalid = 1'b0;
    logic        mag_tlast = 1'b0;
    logic        search_done = 1'b0;
    logic [10:0] peak_in = '0;
    logic [10:0] peak_out;
    logic        frame_start, search_start, peak_valid, busy, err_abort, err_timeout;
    logic [7:0]  overrun_count;

    int errors = 0;
    int checks = 0;

    fft_frame_scheduler #(
        .PERIOD_CYCLES  (P),
        .FRAME_LEN      (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_104mhz    (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_done   (sample_done),
        .frame_start   (frame_start),
        .frame_tvalid  (frame_tvalid),
        .frame_tready  (frame_tready),
        .frame_tlast   (frame_tlast),
        .last_missing  (last_missing),
        .mag_tvalid    (mag_tvalid),
        .mag_tlast     (mag_tlast),
        .search_start  (search_start),
        .search_done   (search_done),
        .peak_in       (peak_in),
        .peak_out      (peak_out),
        .peak_valid    (peak_valid),
        .busy          (busy),
        .err_abort     (err_abort),
        .err_timeout   (err_timeout),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_SEND = 1, M_WAIT = 2, M_SEARCH = 3;
    int          m_phase = 0, m_prev = 0, m_cyc = 0, m_fill = 0, m_beats = 0, m_age = 0, m_raw = 0;
    bit          m_tick, m_beat;
    logic        e_fs = 0, e_ss = 0, e_pv = 0, e_abort = 0, e_timeout = 0;
    logic [10:0] e_peak = '0;

    // Model: a tick every P cycles since reset; a frame walks through its
    // phases; age counts cycles spent in the current busy phase.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = M_IDLE; m_cyc = 0; m_fill = 0; m_beats = 0; m_age = 0; m_raw = 0;
            e_fs = 0; e_ss = 0; e_pv = 0; e_abort = 0; e_timeout = 0; e_peak = '0;
        end else begin
            m_tick = (m_cyc % P) == P - 1;
            m_cyc  = m_cyc + 1;
            m_prev = m_phase;
            m_beat = frame_tvalid && frame_tready;
            e_fs = 0; e_ss = 0; e_pv = 0;
            if (m_tick && m_phase != M_IDLE) m_raw = m_raw + 1;
            if (m_phase != M_IDLE) m_age = m_age + 1;
            case (m_phase)
                M_IDLE: if (m_tick && enable && m_fill == FL) begin
                    m_phase = M_SEND; e_fs = 1; m_beats = 0;
                end
                M_SEND: begin
                    if (last_missing || (m_beat && frame_tlast && m_beats != FL - 1)) begin
                        e_abort = 1; m_phase = M_IDLE;
                    end else if (m_beat && frame_tlast) begin
                        m_phase = M_WAIT;
                    end else if (m_age == TO) begin
                        e_timeout = 1; m_phase = M_IDLE;
                    end else if (m_beat) begin
                        m_beats = m_beats + 1;
                    end
                end
                M_WAIT: begin
                    if (mag_tvalid && mag_tlast) begin
                        m_phase = M_SEARCH; e_ss = 1;
                    end else if (m_age == TO) begin
                        e_timeout = 1; m_phase = M_IDLE;
                    end
                end
                M_SEARCH: begin
                    if (search_done) begin
                        m_phase = M_IDLE; e_pv = 1; e_peak = peak_in;
                    end else if (m_age == TO) begin
                        e_timeout = 1; m_phase = M_IDLE;
                    end
                end
                default: ;
            endcase
            if (m_phase != m_prev) m_age = 0;
            if (sample_done && m_fill < FL) m_fill = m_fill + 1;
        end
    end

    // ---------------- compare process ----------------
    logic [24:0] act_vec, exp_vec;
    logic [7:0]  e_ov;
    int fs_count = 0, ss_count = 0, pv_count = 0, fs_mod = -1;

    // Whole-output comparison every cycle, plus pulse bookkeeping.
    always @(negedge clk) begin
        e_ov    = (m_raw > 255) ? 8'd255 : 8'(m_raw);
        exp_vec = {e_fs, e_ss, e_pv, e_peak, (m_phase != M_IDLE), e_abort, e_timeout, e_ov};
        act_vec = {frame_start, search_start, peak_valid, peak_out, busy, err_abort, err_timeout, overrun_count};
        checks  = checks + 1;
        if (act_vec !== exp_vec) begin
            errors = errors + 1;
            $display("FAIL outputs t=%0t got=%h expected=%h", $time, act_vec, exp_vec);
        end
        if (frame_start === 1'b1) begin
            fs_count = fs_count + 1;
            fs_mod   = m_cyc % P;
        end
        if (search_start === 1'b1) ss_count = ss_count + 1;
        if (peak_valid === 1'b1) pv_count = pv_count + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_samples(input int n);
        repeat (n) begin
            sample_done = 1'b1;
            cyc(1);
        end
        sample_done = 1'b0;
    endtask

    task automatic wait_frame_start(input string name);
        int start;
        int k;
        start = fs_count;
        k = 0;
        while (fs_count == start && k < 3 * P) begin
            cyc(1);
            k++;
        end
        check(name, fs_count - start, 1);
    endtask

    task automatic send_frame(input int nbeats, input bit with_last);
        int b;
        int i;
        b = 0;
        i = 0;
        while (b < nbeats) begin
            frame_tvalid = 1'b1;
            frame_tready = (i % 5) != 4;
            frame_tlast  = with_last && (b == nbeats - 1);
            cyc(1);
            if (frame_tready) b++;
            i++;
        end
        frame_tvalid = 1'b0;
        frame_tready = 1'b0;
        frame_tlast  = 1'b0;
    endtask

    task automatic mag_last();
        mag_tvalid = 1'b1;
        mag_tlast  = 1'b1;
        cyc(1);
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
    endtask

    // Hard stop if anything fails to make progress.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int ov_before;
        int k;
        int pv_before;
        #1 reset = 1'b1;
        cyc(3);
        check("reset_outputs", int'({frame_start, search_start, peak_valid, busy, err_abort,
                                     err_timeout, overrun_count, peak_out}), 0);
        reset  = 1'b0;
        enable = 1'b1;

        // One sample short of a full frame: ticks must be ignored.
        pulse_samples(FL - 1);
        cyc(P + 5);
        check("no_start_before_fill", fs_count, 0);
        check("no_overrun_when_idle", int'(overrun_count), 0);
        pulse_samples(1);
        wait_frame_start("first_frame_start");
        check("start_one_cycle_after_tick", fs_mod, 0);
        $display("frame 1 started at t=%0t", $time);

        // Full frame; enable dropped mid-frame; stray mag_tlast/search_done in SEND.
        enable = 1'b0;
        search_done = 1'b1; mag_tvalid = 1'b1; mag_tlast = 1'b1;
        cyc(1);
        search_done = 1'b0; mag_tvalid = 1'b0; mag_tlast = 1'b0;
        send_frame(FL, 1'b1);
        cyc(3);
        check("wait_mag_busy", int'(busy), 1);
        mag_last();
        check("search_start_entry", int'(search_start), 1);
        cyc(4);
        peak_in = 11'h030;
        search_done = 1'b1;
        cyc(1);
        search_done = 1'b0;
        peak_in = 11'h7ff;
        cyc(2);
        check("search_start_once", ss_count, 1);
        check("peak_out_0x30", int'(peak_out), 48);
        check("peak_valid_one_cycle", pv_count, 1);
        check("idle_after_search", int'(busy), 0);
        check("no_abort_on_enable_low", int'(err_abort), 0);
        $display("frame 1 done peak_out=0x%0h overruns=%0d", peak_out, overrun_count);

        // Enable low while idle: no starts, no overruns.
        ov_before = int'(overrun_count);
        cyc(2 * P + 3);
        check("enable_low_no_start", fs_count, 1);
        check("enable_low_no_overrun", int'(overrun_count), ov_before);

        // Early end: last_missing after 100 beats.
        enable = 1'b1;
        wait_frame_start("abort_frame_start");
        send_frame(100, 1'b0);
        last_missing = 1'b1;
        cyc(1);
        last_missing = 1'b0;
        check("abort_flag", int'(err_abort), 1);
        check("abort_busy_low", int'(busy), 0);
        cyc(5);
        check("abort_no_search", ss_count, 1);
        $display("frame 2 aborted err_abort=%0d", err_abort);

        // Search never completes: timeout after 1000 cycles in SEARCH.
        wait_frame_start("timeout_frame_start");
        send_frame(FL, 1'b1);
        cyc(2);
        mag_last();
        check("timeout_search_start", int'(search_start), 1);
        k = 0;
        while (err_timeout !== 1'b1 && k < 2 * TO) begin
            cyc(1);
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_busy_low", int'(busy), 0);
        check("timeout_no_peak", int'(peak_out), 48);
        $display("frame 3 timed out after %0d cycles in search", k);

        // Stalled frames: each stays busy for TO cycles and drops TO/P ticks.
        ov_before = int'(overrun_count);
        pv_before = pv_count;
        for (int it = 0; it < 30; it++) begin
            wait_frame_start("overrun_frame_start");
            k = 0;
            while (busy && k < 2 * TO) begin
                cyc(1);
                k++;
            end
            if (it == 0) check("overrun_per_busy_tick", int'(overrun_count) - ov_before, TO / P);
            $display("stall frame %0d overrun_count=%0d", it, overrun_count);
        end
        check("overrun_saturated", int'(overrun_count), 255);
        check("stall_no_peak_valid", pv_count, pv_before);

        // Reset while waiting for magnitudes.
        wait_frame_start("reset_frame_start");
        send_frame(FL, 1'b1);
        cyc(2);
        check("in_wait_mag", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", int'({frame_start, search_start, peak_valid, busy, err_abort,
                                          err_timeout, overrun_count, peak_out}), 0);
        cyc(2);
        reset = 1'b0;
        k = fs_count;
        pulse_samples(FL - 1);
        cyc(P + 5);
        check("no_start_after_reset_partial_fill", fs_count, k);
        pulse_samples(1);
        wait_frame_start("restart_after_refill");
        $display("restart after reset at t=%0t", $time);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_scheduler.md
FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1_733_333: clk_104mhz cycles between frame ticks.
REQ-002 SHALL have parameter FRAME_LEN, default 4096: samples per FFT frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000: maximum cycles spent in any busy state.
REQ-004 clk_104mhz  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  allows new frame starts.
REQ-007 sample_done  in  1  one-cycle pulse per oversampled sample written to frame BRAM.
REQ-008 frame_start  out  1  one-cycle pulse that starts the BRAM-to-FFT reader.
REQ-009 frame_tvalid, frame_tready, frame_tlast  in  1 each  sniffed FFT input handshake.
REQ-010 last_missing  in  1  FFT core event: frame ended early.
REQ-011 mag_tvalid, mag_tlast  in  1 each  sniffed FFT magnitude output.
REQ-012 search_start  out  1  one-cycle pulse that starts the peak-bucket search.
REQ-013 search_done  in  1  peak search complete; peak_in is valid in the same cycle.
REQ-014 peak_in  in  11  largest bucket index from the search.
REQ-015 peak_out  out  11  last good peak index.
REQ-016 peak_valid  out  1  one-cycle pulse when peak_out updates.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err_abort, err_timeout  out  1 each  sticky error flags; cleared only by reset.
REQ-019 overrun_count  out  8  saturating count of dropped ticks.

Function
REQ-020 Tick counter SHALL count 0..PERIOD_CYCLES-1 and wrap; it asserts tick for one cycle at PERIOD_CYCLES-1.
REQ-021 Fill counter SHALL saturate at FRAME_LEN, increment on sample_done, and never clear after saturating; frames SHALL NOT start before it reaches FRAME_LEN.
REQ-022 States SHALL be IDLE, SEND, WAIT_MAG and SEARCH.
REQ-023 IDLE->SEND on tick & enable & fill saturated; frame_start pulses on that transition edge (registered, 1-cycle latency from tick).
REQ-024 SEND SHALL count beats (frame_tvalid & frame_tready); on the beat with frame_tlast, it goes to WAIT_MAG.
REQ-025 If a tlast beat arrives with beat count != FRAME_LEN-1, or last_missing is asserted in SEND, then err_abort SHALL set and the block SHALL return to IDLE with no search.
REQ-026 WAIT_MAG->SEARCH on mag_tvalid & mag_tlast; search_start pulses on entry.
REQ-027 SEARCH->IDLE on search_done; peak_out<=peak_in and peak_valid pulses in the following cycle.
REQ-028 A tick while busy, or while enable is low, or before fill saturates, SHALL increment overrun_count only if busy; the count saturates at 255; ticks are never queued.
REQ-029 State timer SHALL clear on each state entry; reaching TIMEOUT_CYCLES in a non-IDLE state sets err_timeout and forces IDLE.
REQ-030 enable deasserted mid-frame SHALL NOT abort; the current frame completes.
REQ-031 Simultaneous timeout and a completing event SHALL give the completing event priority.
REQ-032 search_done or mag_tlast outside its state SHALL be ignored.

Reset
REQ-033 Reset SHALL set: state IDLE, all counters 0, peak_out 0, and all outputs/flags 0.
REQ-034 Reset mid-frame SHALL abandon the frame; a new frame SHALL NOT start until fill saturates again.

Structure
REQ-035 State enum, FRAME_LEN and the bucket index width (11) SHALL live in shared package fft_pkg.
REQ-036 Tick and timeout counters SHALL use one sub-module, cycle_timer (parameterised limit, clear, expired pulse).

Verification
REQ-037 After reset, 4095 sample_done then a tick -> no frame_start; 4096th sample then next tick -> frame_start exactly 1 cycle after the tick.
REQ-038 Full frame of 4096 beats with tlast on beat 4095, mag_tlast, then search_done with peak_in=0x30 -> search_start once, peak_out=0x30, peak_valid 1 cycle.
REQ-039 last_missing at beat 100 -> err_abort=1, busy=0 next cycle, no search_start.
REQ-040 Hold search_done low with TIMEOUT_CYCLES=1000 -> err_timeout at cycle 1000 of SEARCH, state IDLE.
REQ-041 PERIOD_CYCLES=100 with a 250-cycle frame -> overrun_count increments per busy tick; after 300 forced overruns it reads 255.
REQ-042 Assert reset in WAIT_MAG -> all outputs 0 asynchronously; first subsequent frame_start only after 4096 new sample_done pulses.
